// File: rtl/game_pkg.sv
// Shared game types and constants: scroll FSM states, difficulty level codes
// and the default period width.
package game_pkg;

  localparam int DEFAULT_CW = 23;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_IN,
    PLAY,
    PAUSED,
    DONE
  } scroll_state_t;

  localparam logic [1:0] EASY   = 2'd1;
  localparam logic [1:0] MEDIUM = 2'd2;
  localparam logic [1:0] HARD   = 2'd3;

endpackage

// File: rtl/period_timer.sv
// Loadable down-counter. It ticks when it is enabled at zero, and that same edge
// reloads it so that ticks stay exactly load_val+1 cycles apart.
module period_timer #(
  parameter int CW = 23
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          load,
  input  logic          en,
  input  logic [CW-1:0] load_val,
  output logic          tick
);

  logic [CW-1:0] count_q;

  assign tick = en && (count_q == '0);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en) begin
      count_q <= (count_q == '0) ? load_val : count_q - 1'b1;
    end
  end

endmodule

// File: rtl/scroll_scheduler.sv
// Song scroll sequencer: runs a lead-in metronome, then emits one shift_en strobe
// per song beat. It supports pause and abort from the game-mode FSM.
module scroll_scheduler
  import game_pkg::*;
#(
  parameter int CW         = DEFAULT_CW,
  parameter int BW         = 8,
  parameter int SONG_BEATS = 64,
  parameter int LEAD_BEATS = 4,
  parameter int MIN_PERIOD = 1000
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          start,
  input  logic          pause,
  input  logic          abort,
  input  logic [CW-1:0] diff_speed,
  output logic          click,
  output logic          shift_en,
  output logic [BW-1:0] beat_idx,
  output logic          lead_in,
  output logic          playing,
  output logic          song_done
);

  localparam int            LW     = $clog2(LEAD_BEATS + 1);
  localparam logic [CW-1:0] MIN_P  = CW'(MIN_PERIOD);
  localparam logic [LW-1:0] LEAD_L = LW'(LEAD_BEATS - 1);
  localparam logic [BW-1:0] BEAT_L = BW'(SONG_BEATS - 1);

  scroll_state_t state_q, state_d;
  logic          ret_play_q, ret_play_d;
  logic [LW-1:0] lead_q, lead_d;
  logic [BW-1:0] beat_d;
  logic          click_d, shift_d;
  logic          load, clear, tick, timer_en;
  logic [CW-1:0] eff_period, load_val;

  // Short or zero periods are raised to MIN_PERIOD. The timer only samples the
  // value when it loads, so a change mid-interval takes effect from the next load.
  assign eff_period = (diff_speed < MIN_P) ? MIN_P : diff_speed;
  assign load_val   = clear ? '0 : eff_period - 1'b1;
  assign timer_en   = (state_q == LEAD_IN) || (state_q == PLAY);

  period_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (load | clear),
    .en       (timer_en),
    .load_val (load_val),
    .tick     (tick)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer
  // a latch.
  always_comb begin
    state_d    = state_q;
    ret_play_d = ret_play_q;
    lead_d     = lead_q;
    beat_d     = beat_idx;
    click_d    = 1'b0;
    shift_d    = 1'b0;
    load       = 1'b0;
    clear      = 1'b0;
    if (abort) begin
      state_d    = IDLE;
      ret_play_d = 1'b0;
      lead_d     = '0;
      beat_d     = '0;
      clear      = 1'b1;
    end else begin
      unique case (state_q)
        IDLE, DONE: if (start) begin
          state_d = LEAD_IN;
          lead_d  = '0;
          beat_d  = '0;
          load    = 1'b1;
        end
        LEAD_IN: if (tick) begin
          click_d = 1'b1;
          lead_d  = lead_q + 1'b1;
          if (lead_q == LEAD_L) state_d = PLAY;
        end else if (pause) begin
          state_d    = PAUSED;
          ret_play_d = 1'b0;
        end
        PLAY: if (tick) begin
          shift_d = 1'b1;
          if (beat_idx == BEAT_L) begin
            beat_d  = '0;
            state_d = DONE;
          end else begin
            beat_d = beat_idx + 1'b1;
          end
        end else if (pause) begin
          state_d    = PAUSED;
          ret_play_d = 1'b1;
        end
        PAUSED: if (!pause) state_d = ret_play_q ? PLAY : LEAD_IN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Status flags decode the next state so they move on the same edge as the state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      ret_play_q <= 1'b0;
      lead_q     <= '0;
      beat_idx   <= '0;
      click      <= 1'b0;
      shift_en   <= 1'b0;
      lead_in    <= 1'b0;
      playing    <= 1'b0;
      song_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_play_q <= ret_play_d;
      lead_q     <= lead_d;
      beat_idx   <= beat_d;
      click      <= click_d;
      shift_en   <= shift_d;
      lead_in    <= (state_d == LEAD_IN) || (state_d == PAUSED && !ret_play_d);
      playing    <= (state_d == PLAY) || (state_d == PAUSED && ret_play_d);
      song_done  <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_scroll_scheduler.sv
// Self-checking bench for scroll_scheduler. It runs a vector table for a full song,
// directed corner sequences, and a random phase against a cycle-level song model.
module tb_scroll_scheduler;

  localparam int SB = 4;
  localparam int LB = 2;
  localparam int MP = 4;

  logic        tb_clk = 1'b0;
  logic        n_rst, start, pause, abort;
  logic [22:0] diff_speed;
  logic        click, shift_en, lead_in, playing, song_done;
  logic [7:0]  beat_idx;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 tb_clk = ~tb_clk;

  scroll_scheduler #(
    .CW(23), .BW(8), .SONG_BEATS(SB), .LEAD_BEATS(LB), .MIN_PERIOD(MP)
  ) dut (
    .clk        (tb_clk),
    .n_rst      (n_rst),
    .start      (start),
    .pause      (pause),
    .abort      (abort),
    .diff_speed (diff_speed),
    .click      (click),
    .shift_en   (shift_en),
    .beat_idx   (beat_idx),
    .lead_in    (lead_in),
    .playing    (playing),
    .song_done  (song_done)
  );

  // Song model: counts active cycles elapsed in the current beat interval and
  // the beats already scrolled, with the mode kept as plain integers.
  localparam int M_IDLE = 0, M_LEAD = 1, M_PLAY = 2, M_PAUSED = 3, M_DONE = 4;
  int m_mode, m_ret, m_elapsed, m_per, m_lead, m_beat;
  bit m_click, m_shift;

  function automatic int clamp(input int d);
    return (d < MP) ? MP : d;
  endfunction

  function automatic logic [12:0] mk(input bit c, input bit s, input bit li,
                                     input bit pl, input bit dn, input int b);
    return {c, s, li, pl, dn, 8'(b)};
  endfunction

  function automatic logic [12:0] outv();
    return {click, shift_en, lead_in, playing, song_done, beat_idx};
  endfunction

  function automatic logic [12:0] model_out();
    return mk(m_click, m_shift,
              m_mode == M_LEAD || (m_mode == M_PAUSED && m_ret == M_LEAD),
              m_mode == M_PLAY || (m_mode == M_PAUSED && m_ret == M_PLAY),
              m_mode == M_DONE, m_beat);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_ret = M_LEAD; m_elapsed = 0; m_per = MP;
    m_lead = 0; m_beat = 0; m_click = 0; m_shift = 0;
  endtask

  task automatic model_edge(input bit s, input bit p, input bit a, input int d);
    m_click = 0;
    m_shift = 0;
    if (a) begin
      m_mode = M_IDLE; m_beat = 0; m_lead = 0; m_elapsed = 0;
    end else begin
      case (m_mode)
        M_IDLE, M_DONE: if (s) begin
          m_mode = M_LEAD; m_elapsed = 0; m_per = clamp(d); m_lead = 0; m_beat = 0;
        end
        M_LEAD, M_PLAY: if (m_elapsed == m_per - 1) begin
          m_elapsed = 0;
          m_per     = clamp(d);
          if (m_mode == M_LEAD) begin
            m_click = 1;
            m_lead++;
            if (m_lead == LB) m_mode = M_PLAY;
          end else begin
            m_shift = 1;
            m_beat++;
            if (m_beat == SB) begin
              m_beat = 0;
              m_mode = M_DONE;
            end
          end
        end else begin
          m_elapsed++;
          if (p) begin
            m_ret  = m_mode;
            m_mode = M_PAUSED;
          end
        end
        M_PAUSED: if (!p) m_mode = m_ret;
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: update the model with the inputs seen at the edge, then compare 1 ns later.
  task automatic step();
    @(posedge tb_clk);
    if (!n_rst) model_reset();
    else model_edge(start, pause, abort, int'(diff_speed));
    #1;
    cyc++;
    check($sformatf("model@%0d", cyc), 32'(outv()), 32'(model_out()));
  endtask

  task automatic wait_shift(input int budget, output int at);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      if (shift_en) found = 1;
    end
    check("shift_within_budget", 32'(found), 32'd1);
    at = cyc;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        start;
    logic        pause;
    logic        abort;
    int          diff;
    int          cycles;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int c0, c1, c2, c3, ts;
    bit seen;

    vecs[0]  = '{"start_to_lead",   1'b1, 1'b0, 1'b0, 10, 1,  mk(0, 0, 1, 0, 0, 0)};
    vecs[1]  = '{"lead_quiet",      1'b0, 1'b0, 1'b0, 10, 9,  mk(0, 0, 1, 0, 0, 0)};
    vecs[2]  = '{"click_1",         1'b0, 1'b0, 1'b0, 10, 1,  mk(1, 0, 1, 0, 0, 0)};
    vecs[3]  = '{"click_1_one_cyc", 1'b0, 1'b0, 1'b0, 10, 1,  mk(0, 0, 1, 0, 0, 0)};
    vecs[4]  = '{"click_2_to_play", 1'b0, 1'b0, 1'b0, 10, 9,  mk(1, 0, 0, 1, 0, 0)};
    vecs[5]  = '{"shift_1",         1'b0, 1'b0, 1'b0, 10, 10, mk(0, 1, 0, 1, 0, 1)};
    vecs[6]  = '{"shift_2",         1'b0, 1'b0, 1'b0, 10, 10, mk(0, 1, 0, 1, 0, 2)};
    vecs[7]  = '{"shift_3",         1'b0, 1'b0, 1'b0, 10, 10, mk(0, 1, 0, 1, 0, 3)};
    vecs[8]  = '{"shift_4_done",    1'b0, 1'b0, 1'b0, 10, 10, mk(0, 1, 0, 0, 1, 0)};
    vecs[9]  = '{"done_hold",       1'b0, 1'b0, 1'b0, 10, 1,  mk(0, 0, 0, 0, 1, 0)};
    vecs[10] = '{"done_ignores_pause", 1'b0, 1'b1, 1'b0, 10, 5, mk(0, 0, 0, 0, 1, 0)};

    n_rst = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0; diff_speed = 23'd10;
    model_reset();
    #2;
    check("reset_state", 32'(outv()), 32'd0);
    @(posedge tb_clk);
    #1;
    n_rst = 1'b1;

    // Full song via table.
    foreach (vecs[k]) begin
      start = vecs[k].start; pause = vecs[k].pause; abort = vecs[k].abort;
      diff_speed = 23'(vecs[k].diff);
      step();
      start = 1'b0; abort = 1'b0;
      for (int i = 1; i < vecs[k].cycles; i++) step();
      check(vecs[k].name, 32'(outv()), 32'(vecs[k].exp));
    end
    pause = 1'b0;

    // Restart from DONE, then a period change mid-interval.
    diff_speed = 23'd10;
    pulse_start();
    ts = cyc;
    check("restart_from_done", 32'({lead_in, song_done}), 32'b10);
    wait_shift(60, c0);
    check("first_shift_latency", 32'(c0 - ts), 32'd30);
    repeat (3) step();
    diff_speed = 23'd20;
    wait_shift(40, c1);
    check("old_period_finishes", 32'(c1 - c0), 32'd10);
    wait_shift(40, c2);
    check("new_period_applies", 32'(c2 - c1), 32'd20);
    wait_shift(40, c3);
    check("song_done_after_last", 32'(song_done), 32'd1);

    // Pause mid-interval, then pause landing on a tick.
    diff_speed = 23'd10;
    pulse_start();
    wait_shift(70, c0);
    repeat (3) step();
    pause = 1'b1;
    seen = 0;
    repeat (7) begin
      step();
      if (shift_en) seen = 1;
    end
    check("pause_no_strobe", 32'(seen), 32'd0);
    check("pause_holds_beat", 32'(beat_idx), 32'd1);
    pause = 1'b0;
    wait_shift(40, c1);
    check("pause_delay_7", 32'(c1 - c0), 32'd17);
    check("beat_after_pause", 32'(beat_idx), 32'd2);
    repeat (9) step();
    pause = 1'b1;
    step();
    check("pause_tick_strobe", 32'({shift_en, beat_idx}), 32'({1'b1, 8'd3}));
    step();
    step();
    check("pause_after_tick", 32'({shift_en, playing}), 32'b01);
    pause = 1'b0;
    wait_shift(40, c2);
    check("pause_tick_resume", 32'(c2 - c1), 32'd22);

    // Clamp of short and zero periods.
    diff_speed = 23'd2;
    pulse_start();
    wait_shift(40, c0);
    wait_shift(10, c1);
    check("clamp_2", 32'(c1 - c0), 32'd4);
    diff_speed = 23'd0;
    wait_shift(10, c2);
    wait_shift(10, c3);
    check("clamp_0", 32'(c3 - c2), 32'd4);

    // Abort in PLAY, then start+abort together in IDLE.
    diff_speed = 23'd10;
    pulse_start();
    wait_shift(60, c0);
    wait_shift(20, c1);
    repeat (3) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_to_idle", 32'({playing, lead_in, song_done, beat_idx}), 32'd0);
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", 32'({lead_in, playing}), 32'd0);
    repeat (30) step();
    check("idle_stays_quiet", 32'(outv()), 32'd0);

    // Asynchronous reset in the middle of a PLAY cycle.
    pulse_start();
    wait_shift(60, c0);
    repeat (2) step();
    #3;
    n_rst = 1'b0;
    #1;
    check("async_reset", 32'(outv()), 32'd0);
    model_reset();
    step();
    n_rst = 1'b1;
    repeat (25) step();
    check("post_reset_idle", 32'(outv()), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 24) == 0);
      abort = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      if ($urandom_range(0, 39) == 0) diff_speed = 23'($urandom_range(0, 14));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scroll_scheduler.md
Name: scroll_scheduler

Overview:
Sequences note scrolling for one song. Consumes the per-level scroll period from the difficulty block and produces single-cycle scroll strobes for the note shift datapath. Runs a lead-in metronome, counts song beats and supports pause and abort. Sits between the game-mode FSM (start/pause/abort) and the note shift register.

Parameters:
CW, 23, width of period input and internal down-counter
BW, 8, width of beat index
SONG_BEATS, 64, number of scroll beats per song (1..2^BW)
LEAD_BEATS, 4, metronome ticks before first scroll (>=1)
MIN_PERIOD, 1000, minimum effective period in clk cycles (>=2)

Ports:
clk  in  1  system clock (12 MHz)
n_rst  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a song
pause  in  1  level; freezes timing while high
abort  in  1  single-cycle request to return to idle
diff_speed  in  CW  requested period in clk cycles, from difficulty block
click  out  1  one-cycle metronome pulse per lead-in tick
shift_en  out  1  one-cycle note-scroll strobe per song beat
beat_idx  out  BW  index of the next beat to scroll
lead_in  out  1  high in LEAD_IN state and while paused from it
playing  out  1  high in PLAY state and while paused from it
song_done  out  1  high in DONE

Behaviour:
- Reset (async, n_rst=0): state IDLE, counter 0, lead count 0, beat_idx 0, all 1-bit outputs 0.
- eff_period = max(diff_speed, MIN_PERIOD); diff_speed=0 also clamped. Sampled only when counter loads.
- States: IDLE, LEAD_IN, PLAY, PAUSED, DONE. PAUSED holds a 1-bit return state (LEAD_IN/PLAY).
- Timer: load value eff_period-1; decrements by 1 per cycle in LEAD_IN/PLAY; frozen elsewhere. Counter==0 in LEAD_IN/PLAY = tick; same edge reloads with eff_period-1. Ticks exactly eff_period cycles apart.
- Period change mid-interval: current interval finishes with old value; new value applies from next load.
- IDLE: start -> LEAD_IN, counter loads, lead count 0, beat_idx 0. Other inputs ignored.
- LEAD_IN: each tick asserts click for the following cycle (registered); lead count +1. Tick with lead count == LEAD_BEATS-1 -> PLAY. First click lands eff_period cycles after the start edge.
- PLAY: each tick asserts shift_en for the following cycle; beat_idx +1. Tick with beat_idx == SONG_BEATS-1 -> DONE, shift_en still pulses for that beat; beat_idx wraps to 0.
- PAUSED: entered from LEAD_IN/PLAY when pause=1 and no tick that cycle; counter, lead count, beat_idx held; no click/shift_en. pause=0 -> return state, counting resumes next cycle. Pause never loses or duplicates a beat.
- Tick and pause same cycle: tick processed (strobe, count, possible state change), then PAUSED from the next cycle if pause still high. Tick that reaches DONE ignores pause.
- DONE: song_done=1 held; start -> LEAD_IN (restart, same as from IDLE); pause ignored.
- abort: highest priority in every state; next cycle state IDLE, counter/lead/beat_idx 0, outputs 0 (a strobe already registered this cycle is cleared).
- start in LEAD_IN/PLAY/PAUSED ignored. start and abort together: abort wins.
- Status outputs are registered and change on the same edge as the state.

Decomposition:
- Shared package game_pkg: scroll_state_t enum (IDLE, LEAD_IN, PLAY, PAUSED, DONE); level constants EASY=2'd1, MEDIUM=2'd2, HARD=2'd3; default CW=23.
- Sub-module period_timer: loadable down-counter (inputs load, en, load_val; output tick when value==0 and en), with the reload-on-tick rule above. Top owns FSM, clamp, counters, strobes.

Test Plan:
(All with SONG_BEATS=4, LEAD_BEATS=2, MIN_PERIOD=4.)
- Reset: assert n_rst mid-cycle during PLAY -> all outputs 0 immediately, beat_idx 0; after release stays IDLE with no strobes.
- Full song, diff_speed=10: start -> click at +10 and +20 cycles, shift_en at +30,+40,+50,+60; beat_idx 1,2,3,0 after each; song_done from the cycle after the last strobe; no other strobes.
- Period change: diff_speed 10 -> 20 three cycles after a shift_en -> next strobe still 10 after the previous one, following one 20 later.
- Pause: pause high 7 cycles mid-interval in PLAY -> no strobe while paused, next shift_en delayed exactly 7 cycles, beat_idx unchanged; pause in the same cycle as a tick -> strobe still emitted once.
- Clamp: diff_speed=2, then 0 -> strobes every 4 cycles in both cases.
- Abort/restart: abort in PLAY after 2 beats -> IDLE next cycle, beat_idx 0, playing 0; start and abort together in IDLE -> stays IDLE; start in DONE -> LEAD_IN, song_done 0, full song repeats.
